// File: rtl/uart_bridge_pkg.sv
// Shared definitions for the UART <-> Wishbone bridge pair: state encoding,
// header layout, status codes and wire byte-count helpers.
package uart_bridge_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_RX_FRAME = 2'd1,
        ST_WB_CYCLE = 2'd2,
        ST_TX_RESP  = 2'd3
    } bridge_state_e;

    localparam int HDR_WE_BIT = 0;

    localparam logic [7:0] ACK_OK      = 8'h01;
    localparam logic [7:0] ACK_TIMEOUT = 8'h00;

    function automatic int addr_bytes(input int aw);
        return ((aw / 8) < 1) ? 1 : (aw / 8);
    endfunction

    function automatic int data_bytes(input int dw);
        return ((dw / 8) < 1) ? 1 : (dw / 8);
    endfunction

    // Total request bytes on the wire, header included.
    function automatic int frame_bytes(input logic we, input int aw, input int dw);
        return we ? (1 + addr_bytes(aw) + data_bytes(dw) + 1) : (1 + addr_bytes(aw));
    endfunction

    function automatic int resp_bytes(input logic we, input int dw);
        return we ? 1 : data_bytes(dw);
    endfunction

endpackage

// File: rtl/uart2wb_frame_rx.sv
// Request frame assembler: header check, byte counting, request register and
// inter-byte timeout. Field outputs show the register including the byte just accepted.
module uart_frame_rx
    import uart_bridge_pkg::*;
#(
    parameter int addr_width     = 4,
    parameter int data_width     = 8,
    parameter int strobe_width   = 1,
    parameter int timeout_cycles = 65535
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    enable,
    input  logic [7:0]              rx_byte,
    input  logic                    rx_valid,
    output logic                    frame_done,
    output logic                    req_we,
    output logic [addr_width-1:0]   req_adr,
    output logic [data_width-1:0]   req_datwr,
    output logic [strobe_width-1:0] req_sel
);
    localparam int AB    = addr_bytes(addr_width);
    localparam int DB    = data_bytes(data_width);
    localparam int PB    = AB + DB + 1;
    localparam int REQ_W = 8 * PB;
    localparam int CNT_W = $clog2(PB + 2);
    localparam int TW    = $clog2(timeout_cycles + 1);
    localparam logic [CNT_W-1:0] RD_LEN   = CNT_W'(frame_bytes(1'b0, addr_width, data_width));
    localparam logic [CNT_W-1:0] WR_LEN   = CNT_W'(frame_bytes(1'b1, addr_width, data_width));
    localparam logic [TW-1:0]    TMO_LAST = TW'(timeout_cycles - 1);

    bridge_state_e    state_q, state_d;
    logic             we_q, we_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, slot_s, exp_len_s;
    logic [REQ_W-1:0] req_q, req_d;
    logic [TW-1:0]    tmo_q, tmo_d;

    // Header acceptance, payload capture and partial-frame timeout.
    always_comb begin
        state_d    = state_q;
        we_d       = we_q;
        cnt_d      = cnt_q;
        req_d      = req_q;
        tmo_d      = tmo_q;
        frame_done = 1'b0;
        slot_s     = cnt_q - CNT_W'(1);
        exp_len_s  = we_q ? WR_LEN : RD_LEN;
        case (state_q)
            ST_IDLE: begin
                tmo_d = '0;
                if (enable && rx_valid && (rx_byte[7:1] == 7'd0)) begin
                    we_d    = rx_byte[HDR_WE_BIT];
                    cnt_d   = CNT_W'(1);
                    req_d   = '0;
                    state_d = ST_RX_FRAME;
                end else begin
                    cnt_d = '0;
                end
            end
            ST_RX_FRAME: begin
                if (rx_valid) begin
                    req_d[{slot_s, 3'b000} +: 8] = rx_byte;
                    cnt_d = cnt_q + CNT_W'(1);
                    tmo_d = '0;
                    if ((cnt_q + CNT_W'(1)) == exp_len_s) begin
                        frame_done = 1'b1;
                        state_d    = ST_IDLE;
                    end else begin
                        state_d = ST_RX_FRAME;
                    end
                end else if (tmo_q == TMO_LAST) begin
                    tmo_d   = '0;
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
                tmo_d   = '0;
            end
        endcase
    end

    assign req_we    = we_q;
    assign req_adr   = req_d[addr_width-1:0];
    assign req_datwr = req_d[8*AB +: data_width];
    assign req_sel   = we_q ? req_d[8*(AB+DB) +: strobe_width] : {strobe_width{1'b1}};

    // Assembler state register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            we_q    <= 1'b0;
            cnt_q   <= '0;
            req_q   <= '0;
            tmo_q   <= '0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            cnt_q   <= cnt_d;
            req_q   <= req_d;
            tmo_q   <= tmo_d;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// UART receiver, 8N1, LSB first; pulses data_valid for one clock at mid stop bit.
module uart_rx #(
    parameter int CLK_PER_BIT = 217
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] data_out,
    output logic       data_valid
);
    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;

    localparam int CW = $clog2(CLK_PER_BIT + 1);
    localparam logic [CW-1:0] LAST = CW'(CLK_PER_BIT - 1);
    localparam logic [CW-1:0] HALF = CW'(CLK_PER_BIT / 2);

    rx_state_e       state_q, state_d;
    logic [1:0]      sync_q;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [2:0]      bit_q, bit_d;
    logic [7:0]      shift_q, shift_d;
    logic            valid_q, valid_d;
    logic            rx_s;

    assign rx_s       = sync_q[1];
    assign data_out   = shift_q;
    assign data_valid = valid_q;

    // Two-flop synchroniser on the asynchronous serial input.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= {sync_q[0], rx};
        end
    end

    // Bit timing: start bit verified at half a bit, data/stop sampled mid-bit.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        valid_d = 1'b0;
        case (state_q)
            RX_IDLE: begin
                cnt_d = '0;
                bit_d = 3'd0;
                if (!rx_s) begin
                    state_d = RX_START;
                end else begin
                    state_d = RX_IDLE;
                end
            end
            RX_START: begin
                if (cnt_q == HALF) begin
                    cnt_d   = '0;
                    state_d = rx_s ? RX_IDLE : RX_DATA;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            RX_DATA: begin
                if (cnt_q == LAST) begin
                    cnt_d   = '0;
                    shift_d = {rx_s, shift_q[7:1]};
                    if (bit_q == 3'd7) begin
                        state_d = RX_STOP;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            RX_STOP: begin
                if (cnt_q == LAST) begin
                    cnt_d   = '0;
                    valid_d = rx_s;
                    state_d = RX_IDLE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                state_d = RX_IDLE;
            end
        endcase
    end

    // Receiver state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= RX_IDLE;
            cnt_q   <= '0;
            bit_q   <= 3'd0;
            shift_q <= 8'h00;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            valid_q <= valid_d;
        end
    end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter, 8N1, LSB first; a load during tx_done chains bytes with no idle gap.
module uart_tx #(
    parameter int CLK_PER_BIT = 217
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       data_load,
    input  logic [7:0] data_in,
    output logic       tx,
    output logic       tx_done
);
    localparam int CW = $clog2(CLK_PER_BIT + 1);
    localparam logic [CW-1:0] LAST = CW'(CLK_PER_BIT - 1);

    logic          busy_q, busy_d;
    logic [9:0]    shift_q, shift_d;
    logic [3:0]    bit_q, bit_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          tx_q, tx_d;

    assign tx      = tx_q;
    assign tx_done = busy_q && (cnt_q == LAST) && (bit_q == 4'd9);

    // Frame shifter: {stop, data, start} shifted out one bit per CLK_PER_BIT.
    always_comb begin
        busy_d  = busy_q;
        shift_d = shift_q;
        bit_d   = bit_q;
        cnt_d   = cnt_q;
        if (data_load && (!busy_q || tx_done)) begin
            busy_d  = 1'b1;
            shift_d = {1'b1, data_in, 1'b0};
            bit_d   = 4'd0;
            cnt_d   = '0;
        end else if (busy_q) begin
            if (cnt_q == LAST) begin
                cnt_d   = '0;
                shift_d = {1'b1, shift_q[9:1]};
                if (bit_q == 4'd9) begin
                    busy_d = 1'b0;
                    bit_d  = 4'd0;
                end else begin
                    bit_d = bit_q + 4'd1;
                end
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end else begin
            cnt_d = '0;
        end
        tx_d = busy_d ? shift_d[0] : 1'b1;
    end

    // Transmitter state register; line idles high.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_q  <= 1'b0;
            shift_q <= 10'h3FF;
            bit_q   <= 4'd0;
            cnt_q   <= '0;
            tx_q    <= 1'b1;
        end else begin
            busy_q  <= busy_d;
            shift_q <= shift_d;
            bit_q   <= bit_d;
            cnt_q   <= cnt_d;
            tx_q    <= tx_d;
        end
    end

endmodule

// File: rtl/uart2wb.sv
// Remote-side bridge: UART request frame in, one Wishbone master cycle, UART
// response frame out. Half-duplex: bytes arriving while busy are dropped.
module uart2wb
    import uart_bridge_pkg::*;
#(
    parameter int addr_width     = 4,
    parameter int data_width     = 8,
    parameter int strobe_width   = ((data_width / 8) < 1) ? 1 : (data_width / 8),
    parameter int clk_per_bit    = 217,
    parameter int timeout_cycles = 65535
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    uart_rx,
    output logic                    uart_tx,
    output logic [addr_width-1:0]   wb_adr,
    output logic [data_width-1:0]   wb_datwr,
    input  logic [data_width-1:0]   wb_datrd,
    output logic                    wb_we,
    output logic [strobe_width-1:0] wb_sel,
    output logic                    wb_stb,
    output logic                    wb_cyc,
    input  logic                    wb_ack
);
    localparam int DB    = data_bytes(data_width);
    localparam int IDX_W = (DB > 1) ? $clog2(DB) : 1;
    localparam int TW    = $clog2(timeout_cycles + 1);
    localparam logic [IDX_W-1:0] RD_LAST  = IDX_W'(resp_bytes(1'b0, data_width) - 1);
    localparam logic [IDX_W-1:0] WR_LAST  = IDX_W'(resp_bytes(1'b1, data_width) - 1);
    localparam logic [TW-1:0]    TMO_LAST = TW'(timeout_cycles - 1);

    logic [7:0]              rx_byte_s, tx_byte_s;
    logic                    rx_valid_s, tx_done_s, data_load_s;
    logic                    frame_done_s, req_we_s;
    logic [addr_width-1:0]   req_adr_s;
    logic [data_width-1:0]   req_datwr_s;
    logic [strobe_width-1:0] req_sel_s;
    logic [IDX_W-1:0]        byte_idx_s, last_idx_s;

    bridge_state_e           state_q, state_d;
    logic                    cyc_q, cyc_d;
    logic                    we_q, we_d;
    logic [addr_width-1:0]   adr_q, adr_d;
    logic [data_width-1:0]   datwr_q, datwr_d;
    logic [strobe_width-1:0] sel_q, sel_d;
    logic [TW-1:0]           tmo_q, tmo_d;
    logic [data_width-1:0]   rd_q, rd_d;
    logic [7:0]              status_q, status_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic                    started_q, started_d;

    uart_rx #(.CLK_PER_BIT(clk_per_bit)) u_uart_rx (
        .clk        (clock),
        .rst        (~reset),
        .rx         (uart_rx),
        .data_out   (rx_byte_s),
        .data_valid (rx_valid_s)
    );

    uart_tx #(.CLK_PER_BIT(clk_per_bit)) u_uart_tx (
        .clk       (clock),
        .rst       (~reset),
        .data_load (data_load_s),
        .data_in   (tx_byte_s),
        .tx        (uart_tx),
        .tx_done   (tx_done_s)
    );

    uart_frame_rx #(
        .addr_width     (addr_width),
        .data_width     (data_width),
        .strobe_width   (strobe_width),
        .timeout_cycles (timeout_cycles)
    ) u_frame_rx (
        .clock      (clock),
        .reset      (reset),
        .enable     (state_q == ST_IDLE),
        .rx_byte    (rx_byte_s),
        .rx_valid   (rx_valid_s),
        .frame_done (frame_done_s),
        .req_we     (req_we_s),
        .req_adr    (req_adr_s),
        .req_datwr  (req_datwr_s),
        .req_sel    (req_sel_s)
    );

    assign wb_cyc   = cyc_q;
    assign wb_stb   = cyc_q;
    assign wb_we    = we_q;
    assign wb_adr   = adr_q;
    assign wb_datwr = datwr_q;
    assign wb_sel   = sel_q;

    // Bridge sequencing: bus cycle with ack/timeout, then response byte stream.
    always_comb begin
        state_d     = state_q;
        cyc_d       = cyc_q;
        we_d        = we_q;
        adr_d       = adr_q;
        datwr_d     = datwr_q;
        sel_d       = sel_q;
        tmo_d       = tmo_q;
        rd_d        = rd_q;
        status_d    = status_q;
        idx_d       = idx_q;
        started_d   = started_q;
        data_load_s = 1'b0;
        byte_idx_s  = idx_q;
        last_idx_s  = we_q ? WR_LAST : RD_LAST;
        case (state_q)
            ST_IDLE: begin
                if (frame_done_s) begin
                    cyc_d   = 1'b1;
                    we_d    = req_we_s;
                    adr_d   = req_adr_s;
                    datwr_d = req_datwr_s;
                    sel_d   = req_sel_s;
                    tmo_d   = '0;
                    state_d = ST_WB_CYCLE;
                end else begin
                    cyc_d = 1'b0;
                end
            end
            ST_WB_CYCLE: begin
                // Ack is checked first so it wins over a coincident timeout.
                if (wb_ack) begin
                    rd_d      = wb_datrd;
                    status_d  = ACK_OK;
                    cyc_d     = 1'b0;
                    idx_d     = '0;
                    started_d = 1'b0;
                    state_d   = ST_TX_RESP;
                end else if (tmo_q == TMO_LAST) begin
                    rd_d      = '0;
                    status_d  = ACK_TIMEOUT;
                    cyc_d     = 1'b0;
                    idx_d     = '0;
                    started_d = 1'b0;
                    state_d   = ST_TX_RESP;
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
            end
            ST_TX_RESP: begin
                if (!started_q) begin
                    data_load_s = 1'b1;
                    started_d   = 1'b1;
                end else if (tx_done_s) begin
                    if (idx_q == last_idx_s) begin
                        started_d = 1'b0;
                        state_d   = ST_IDLE;
                    end else begin
                        idx_d       = idx_q + IDX_W'(1);
                        byte_idx_s  = idx_q + IDX_W'(1);
                        data_load_s = 1'b1;
                    end
                end else begin
                    started_d = 1'b1;
                end
            end
            default: begin
                cyc_d   = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
        tx_byte_s = we_q ? status_q : rd_q[{byte_idx_s, 3'b000} +: 8];
    end

    // Bridge state and bus output registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            cyc_q     <= 1'b0;
            we_q      <= 1'b0;
            adr_q     <= '0;
            datwr_q   <= '0;
            sel_q     <= '0;
            tmo_q     <= '0;
            rd_q      <= '0;
            status_q  <= 8'h00;
            idx_q     <= '0;
            started_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cyc_q     <= cyc_d;
            we_q      <= we_d;
            adr_q     <= adr_d;
            datwr_q   <= datwr_d;
            sel_q     <= sel_d;
            tmo_q     <= tmo_d;
            rd_q      <= rd_d;
            status_q  <= status_d;
            idx_q     <= idx_d;
            started_q <= started_d;
        end
    end

endmodule
